// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS data-side memory responder:
// the I/O page map and the STATUS bit layout.
package mips_mem_pkg;

  localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] CYCLE_ADDR  = IO_BASE + 32'h0000_0000;
  localparam logic [31:0] TXDATA_ADDR = IO_BASE + 32'h0000_0004;
  localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'h0000_0008;

  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO: circular buffer with one-bit-wider pointers.
// The head word and its valid flag are held in registers.
module tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [31:0]                data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                head_o,
  output logic                       valid_o,
  output logic                       ovf_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]      head_q, head_d;
  logic             valid_q, valid_d;
  logic [PTR_W-1:0] count_c;
  logic             full_c, empty_c, pop_ok_c, push_ok_c;

  assign count_c   = wr_q - rd_q;
  assign full_c    = (count_c == PTR_W'(DEPTH));
  assign empty_c   = (count_c == '0);
  assign pop_ok_c  = pop_i && !empty_c;
  assign push_ok_c = push_i && (!full_c || pop_ok_c);

  // Next head: a word pushed into an otherwise-drained FIFO bypasses the array.
  always_comb begin
    rd_d    = rd_q + PTR_W'(pop_ok_c);
    wr_d    = wr_q + PTR_W'(push_ok_c);
    valid_d = (wr_d != rd_d);
    head_d  = '0;
    if (valid_d) begin
      if (push_ok_c && (wr_q == rd_d)) head_d = data_i;
      else                             head_d = mem_q[rd_d[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok_c) mem_q[wr_q[IDX_W-1:0]] <= data_i;
  end

  assign full_o  = full_c;
  assign empty_o = empty_c;
  assign count_o = count_c;
  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign ovf_o   = push_i && !push_ok_c;

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-side memory responder for the pipelined MIPS core: word RAM plus an
// I/O page with a cycle counter, a TX FIFO and its status register.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram_q [RAM_WORDS];
  logic [31:0]      cycle_q, cycle_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      word_addr_c, status_c;
  logic             ram_hit_c, cycle_hit_c, tx_hit_c, status_hit_c;
  logic             wr_en_c, push_c;
  logic             fifo_full, fifo_empty, fifo_ovf;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_addr_lsbs;

  // Byte-lane bits play no part in word accesses.
  assign unused_addr_lsbs = ^ALUOutM[1:0];

  assign word_addr_c  = {ALUOutM[31:2], 2'b00};
  assign ram_hit_c    = (ALUOutM[31:RAM_AW+2] == '0);
  assign cycle_hit_c  = (word_addr_c == CYCLE_ADDR);
  assign tx_hit_c     = (word_addr_c == TXDATA_ADDR);
  assign status_hit_c = (word_addr_c == STATUS_ADDR);
  assign wr_en_c      = MemWriteM && !reset;
  assign push_c       = wr_en_c && tx_hit_c;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .data_i  (WriteDataM),
    .pop_i   (tx_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (tx_data),
    .valid_o (tx_valid),
    .ovf_o   (fifo_ovf)
  );

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ovf_d   = ovf_q || fifo_ovf;
    if (wr_en_c && cycle_hit_c)  cycle_d = '0;
    if (wr_en_c && status_hit_c) ovf_d   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c && ram_hit_c) ram_q[ALUOutM[RAM_AW+1:2]] <= WriteDataM;
  end

  always_comb begin
    status_c = '0;
    status_c[ST_FULL_BIT]  = fifo_full;
    status_c[ST_EMPTY_BIT] = fifo_empty;
    status_c[ST_OVF_BIT]   = ovf_q;
    status_c[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
  end

  always_comb begin
    ReadDataM = '0;
    if (ram_hit_c)         ReadDataM = ram_q[ALUOutM[RAM_AW+1:2]];
    else if (cycle_hit_c)  ReadDataM = cycle_q;
    else if (status_hit_c) ReadDataM = status_c;
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: directed table, hand-written
// FIFO/reset sequences, and randomized traffic against a queue-based model.
module tb_mips_dmem_responder;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam int unsigned DEPTH      = 8;
  localparam logic [31:0] RAM_TOP    = 32'(RAM_WORDS * 4);
  localparam logic [31:0] A_CYCLE    = 32'hFFFF_0000;
  localparam logic [31:0] A_TX       = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS   = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset, MemWriteM, tx_ready, tx_valid;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM, tx_data;

  always #5 clk = ~clk;

  mips_dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_init = 1'b0;
  logic [31:0] m_cyc;
  logic [31:0] m_q[$];
  bit          m_ovf;
  logic [31:0] m_ram[int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wordof(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    if (wordof(a) < RAM_TOP) return m_ram.exists(int'(wordof(a)));
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = wordof(a);
    if (w < RAM_TOP) return m_ram[int'(w)];
    if (w == A_CYCLE) return m_cyc;
    if (w == A_STATUS)
      return {16'h0, 8'(m_q.size()), 5'h0, m_ovf,
              (m_q.size() == 0), (m_q.size() == int'(DEPTH))};
    return 32'h0;
  endfunction

  task automatic model_tick();
    int  sz;
    bit  do_pop;
    logic [31:0] w, junk;
    if (reset) begin
      m_cyc = 0; m_q.delete(); m_ovf = 0; m_init = 1'b1;
      return;
    end
    sz     = m_q.size();
    do_pop = (sz > 0) && tx_ready;
    w      = wordof(ALUOutM);
    m_cyc  = m_cyc + 1;
    if (do_pop) junk = m_q.pop_front();
    if (MemWriteM) begin
      if (w < RAM_TOP)        m_ram[int'(w)] = WriteDataM;
      else if (w == A_CYCLE)  m_cyc = 0;
      else if (w == A_STATUS) m_ovf = 0;
      else if (w == A_TX) begin
        if (sz < int'(DEPTH) || do_pop) m_q.push_back(WriteDataM);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    reset = rst; MemWriteM = we; ALUOutM = a; WriteDataM = d; tx_ready = rdy;
    #1;
  endtask

  // Compare against the model, advance the model, then cross one clock edge.
  task automatic step();
    if (m_init) begin
      chk("tx_valid_model", {31'h0, tx_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
      if (m_q.size() > 0) chk("tx_data_model", tx_data, m_q[0]);
      if (m_known(ALUOutM)) chk("rd_model", ReadDataM, m_read(ALUOutM));
    end
    model_tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        check;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [31:0] exp_seq[8];

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0000, 32'h55AA_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b1, RAM_TOP,       32'h0000_1234, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, RAM_TOP,       32'h0,         1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h55AA_0000};
    tbl[7]  = '{1'b1, RAM_TOP - 4,   32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, RAM_TOP - 1,   32'h0,         1'b1, 32'hCAFE_F00D};
    tbl[9]  = '{1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b0, A_TX,          32'h0,         1'b1, 32'h0};
    tbl[11] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0000_0002};

    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();

    // Reset state and cycle counter
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_tx_data", tx_data, 32'h0);
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("rst_status", ReadDataM, 32'h0000_0002);
    drive(1'b0, 1'b0, A_CYCLE, 32'h0, 1'b0);
    chk("cycle_0", ReadDataM, 32'd0);
    step();
    chk("cycle_1", ReadDataM, 32'd1);
    repeat (4) step();
    chk("cycle_5", ReadDataM, 32'd5);
    repeat (5) step();
    drive(1'b0, 1'b1, A_CYCLE, 32'h0000_0123, 1'b0);
    chk("cycle_10", ReadDataM, 32'd10);
    step();
    drive(1'b0, 1'b0, A_CYCLE, 32'h0, 1'b0);
    chk("cycle_clr", ReadDataM, 32'd0);
    step();
    chk("cycle_clr_1", ReadDataM, 32'd1);
    step();

    // Directed RAM / decode table
    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0);
      if (tbl[i].check) chk($sformatf("tbl_%0d", i), ReadDataM, tbl[i].exp);
      step();
    end

    // Overflow on the ninth push, then drain in order
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, A_TX, 32'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_ovf_full", ReadDataM, 32'h0000_0805);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1);
      chk($sformatf("drain_%0d", i), tx_data, 32'(i));
      step();
    end
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_drained", ReadDataM, 32'h0000_0006);
    chk("drained_valid", {31'h0, tx_valid}, 32'd0);
    drive(1'b0, 1'b1, A_STATUS, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_ovf_clr", ReadDataM, 32'h0000_0002);

    // Push into a full FIFO while the sink pops on the same edge
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, A_TX, 32'h11 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_full", ReadDataM, 32'h0000_0801);
    drive(1'b0, 1'b1, A_TX, 32'h0000_00AA, 1'b1);
    chk("full_head", tx_data, 32'h11);
    step();
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_push_pop", ReadDataM, 32'h0000_0801);
    for (int i = 0; i < 7; i++) exp_seq[i] = 32'h12 + 32'(i);
    exp_seq[7] = 32'hAA;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1);
      chk($sformatf("order_%0d", i), tx_data, exp_seq[i]);
      step();
    end
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_empty2", ReadDataM, 32'h0000_0002);

    // Mid-stream reset discards queued words but keeps RAM
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, A_TX, 32'h21 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("status_three", ReadDataM, 32'h0000_0300);
    drive(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0BAD, 1'b0);
    step();
    drive(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'd0);
    chk("mid_rst_data", tx_data, 32'h0);
    chk("mid_rst_status", ReadDataM, 32'h0000_0002);
    drive(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk("ram_keeps", ReadDataM, 32'hDEAD_BEEF);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      logic        we, rdy, rst;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        2:       a = RAM_TOP - 4;
        3:       a = RAM_TOP + 32'($urandom_range(0, 63));
        4:       a = A_CYCLE;
        5, 6, 7: a = A_TX | 32'($urandom_range(0, 3));
        8:       a = A_STATUS;
        default: a = 32'hFFFF_000C + 32'($urandom_range(0, 255) << 2);
      endcase
      we  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      drive(rst, we, a, $urandom, rdy);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
